// File: rtl/ps2_sudoku_cmd.sv
// PS/2 set-2 keyboard front end: deserialises frames, checks framing/parity,
// tracks E0/F0 prefixes and emits one-cycle game-engine command strobes.
module ps2_sudoku_cmd #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       engine_ready,
    output logic [3:0] cmd_number,
    output logic       cmd_up,
    output logic       cmd_down,
    output logic       cmd_left,
    output logic       cmd_right,
    output logic       cmd_enter,
    output logic       cmd_valid,
    output logic       frame_error
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {DEC_IDLE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_e;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [9:0]             shift_q, shift_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic [7:0]             byte_q, byte_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   frame_error_q, frame_error_d;
    dec_state_e             state_q, state_d;
    logic [3:0]             cmd_number_q, cmd_number_d;
    logic                   cmd_up_q, cmd_up_d;
    logic                   cmd_down_q, cmd_down_d;
    logic                   cmd_left_q, cmd_left_d;
    logic                   cmd_right_q, cmd_right_d;
    logic                   cmd_enter_q, cmd_enter_d;
    logic                   cmd_valid_q, cmd_valid_d;

    logic fall;
    logic sdata;

    assign fall  = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign sdata = data_sync_q[SYNC_STAGES-1];

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    end

    // shift_q holds bits 0..9 (start, data LSB first, parity); stop is checked live
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        to_cnt_d      = to_cnt_q;
        byte_d        = byte_q;
        byte_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        if (fall) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = '0;
                if (!shift_q[0] && sdata && (^shift_q[9:1])) begin
                    byte_valid_d = 1'b1;
                    byte_d       = shift_q[8:1];
                end else begin
                    frame_error_d = 1'b1;
                end
            end else begin
                shift_d[bit_cnt_q] = sdata;
                bit_cnt_d          = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_d     = '0;
                to_cnt_d      = '0;
                frame_error_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
    end

    always_comb begin
        logic       dec_norm;
        logic       dec_ext;
        logic [3:0] num;
        logic [4:0] dirs;   // {up, down, left, right, enter}
        state_d  = state_q;
        dec_norm = 1'b0;
        dec_ext  = 1'b0;
        num      = 4'd0;
        dirs     = 5'b0;
        if (frame_error_q) begin
            state_d = DEC_IDLE;
        end else if (byte_valid_q) begin
            case (state_q)
                DEC_IDLE: begin
                    if (byte_q == 8'hE0)      state_d = DEC_EXT;
                    else if (byte_q == 8'hF0) state_d = DEC_BRK;
                    else                      dec_norm = 1'b1;
                end
                DEC_EXT: begin
                    if (byte_q == 8'hF0) begin
                        state_d = DEC_EXT_BRK;
                    end else if (byte_q != 8'hE0) begin
                        dec_ext = 1'b1;
                        state_d = DEC_IDLE;
                    end
                end
                default: state_d = DEC_IDLE;
            endcase
        end
        if (dec_norm) begin
            case (byte_q)
                8'h16, 8'h69: num = 4'd1;
                8'h1E, 8'h72: num = 4'd2;
                8'h26, 8'h7A: num = 4'd3;
                8'h25, 8'h6B: num = 4'd4;
                8'h2E, 8'h73: num = 4'd5;
                8'h36, 8'h74: num = 4'd6;
                8'h3D, 8'h6C: num = 4'd7;
                8'h3E, 8'h75: num = 4'd8;
                8'h46, 8'h7D: num = 4'd9;
                8'h5A:        dirs = 5'b00001;
                default:      num = 4'd0;
            endcase
        end
        if (dec_ext) begin
            case (byte_q)
                8'h75:   dirs = 5'b10000;
                8'h72:   dirs = 5'b01000;
                8'h6B:   dirs = 5'b00100;
                8'h74:   dirs = 5'b00010;
                8'h5A:   dirs = 5'b00001;
                default: dirs = 5'b00000;
            endcase
        end
        cmd_valid_d  = engine_ready && ((num != 4'd0) || (dirs != 5'b0));
        cmd_number_d = cmd_valid_d ? num : 4'd0;
        cmd_up_d     = cmd_valid_d & dirs[4];
        cmd_down_d   = cmd_valid_d & dirs[3];
        cmd_left_d   = cmd_valid_d & dirs[2];
        cmd_right_d  = cmd_valid_d & dirs[1];
        cmd_enter_d  = cmd_valid_d & dirs[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q    <= '1;
            data_sync_q   <= '1;
            clk_prev_q    <= 1'b1;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            to_cnt_q      <= '0;
            byte_q        <= '0;
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            state_q       <= DEC_IDLE;
            cmd_number_q  <= '0;
            cmd_up_q      <= 1'b0;
            cmd_down_q    <= 1'b0;
            cmd_left_q    <= 1'b0;
            cmd_right_q   <= 1'b0;
            cmd_enter_q   <= 1'b0;
            cmd_valid_q   <= 1'b0;
        end else begin
            clk_sync_q    <= clk_sync_d;
            data_sync_q   <= data_sync_d;
            clk_prev_q    <= clk_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            to_cnt_q      <= to_cnt_d;
            byte_q        <= byte_d;
            byte_valid_q  <= byte_valid_d;
            frame_error_q <= frame_error_d;
            state_q       <= state_d;
            cmd_number_q  <= cmd_number_d;
            cmd_up_q      <= cmd_up_d;
            cmd_down_q    <= cmd_down_d;
            cmd_left_q    <= cmd_left_d;
            cmd_right_q   <= cmd_right_d;
            cmd_enter_q   <= cmd_enter_d;
            cmd_valid_q   <= cmd_valid_d;
        end
    end

    assign cmd_number  = cmd_number_q;
    assign cmd_up      = cmd_up_q;
    assign cmd_down    = cmd_down_q;
    assign cmd_left    = cmd_left_q;
    assign cmd_right   = cmd_right_q;
    assign cmd_enter   = cmd_enter_q;
    assign cmd_valid   = cmd_valid_q;
    assign frame_error = frame_error_q;
endmodule
